regfile_wb_initiator: RTL and testbench
=======================================

Name: regfile_wb_initiator

Overview:
Write-side initiator for the 32x32 register file: buffers writeback requests from the pipeline and drives the register file's single write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg).
- Holds up to DEPTH pending writes in order.
- Issues at most one write per cycle.
- Reports read-after-write hazards against pending writes.
- Sits between the execute/memory stages and regfile.

Parameters:
DEPTH, 4, pending-write FIFO entries (power of 2, >=2)
DATA_W, 32, register data width
ADDR_W, 5, register index width

Ports:
clock  in  1  sole clock, rising edge
ctrl_reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  1  writeback request valid
req_ready  out  1  request accepted when req_valid && req_ready at rising edge
req_reg  in  ADDR_W  destination register index
req_data  in  DATA_W  write data
flush  in  1  discard all pending and in-flight writes
wb_stall  in  1  register file write port unavailable; hold issue
ctrl_writeEnable  out  1  registered write strobe to regfile
ctrl_writeReg  out  ADDR_W  registered write index
data_writeReg  out  DATA_W  registered write data
chk_regA  in  ADDR_W  read index A to check
chk_regB  in  ADDR_W  read index B to check
hazardA  out  1  chk_regA matches a pending/in-flight write
hazardB  out  1  chk_regB matches a pending/in-flight write
byp_validA  out  1  bypass data available for A (feature only)
byp_dataA  out  DATA_W  youngest pending data for chk_regA (feature only)
pend_count  out  $clog2(DEPTH+1)  valid FIFO entries

Behaviour:
- Reset (ctrl_reset=0, async): FIFO empty, pend_count=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, hazardA/B=0, byp_validA=0, byp_dataA=0, req_ready=0.
- Reset release: req_ready=1 from the first cycle after release.
- req_ready = !full && !flush, combinational from registered state.
- Accept: request with req_reg==0 is handshaked (ready honoured) but dropped. Register 0 is never written; pend_count unchanged.
- Push: entry appended at tail on accept.
- Issue: at each rising edge with FIFO non-empty and !wb_stall and !flush, head pops into the output registers. ctrl_writeEnable=1 for exactly that following cycle, with head index and data.
- Issue otherwise: ctrl_writeEnable=0 next cycle. ctrl_writeReg and data_writeReg hold their last values.
- Latency: accept at edge N into an empty FIFO gives ctrl_writeEnable=1 in the cycle after edge N+1; regfile commits at edge N+2. No same-cycle pass-through.
- Back-to-back: with wb_stall=0, one write per cycle; order is strictly FIFO.
- Push and pop in the same edge: pend_count unchanged.
- Full: req_ready=0; a held request is accepted on the first edge after a pop frees a slot.
- wb_stall: freezes issue only. Pushes continue until full. A write already strobed in the current cycle is not repeated.
- flush (sync, priority over push and issue): FIFO emptied, pend_count=0, ctrl_writeEnable=0 next cycle, request in the flush cycle not accepted.
- Hazard: hazardX=1 iff chk_regX!=0 and it equals the index of any valid FIFO entry, or of the output stage while ctrl_writeEnable=1.
- Hazard is purely combinational from current state; no check against the same-cycle incoming request.
- Pointer wrap: read/write pointers ADDR wrap modulo DEPTH. Full and empty are distinguished via pend_count.

Optional Feature:
WB_BYPASS_EN
- Defined: byp_validA mirrors hazardA. byp_dataA = data of the youngest matching entry, with priority FIFO tail..head, then output stage.
- Undefined: byp_validA and byp_dataA tied 0 and no compare-select logic is built. Port list is identical in both builds.

Decomposition:
- Shared package/header regfile_pkg: REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG=5'd0, default WB_DEPTH=4.
- One sub-module wb_fifo: storage plus pointers and count, exposing per-entry valid/index/data vectors for the hazard and bypass compare.
- Compare, issue register and flush logic live in the top.

Test Plan:
- Reset mid-traffic: 3 entries queued, drop ctrl_reset asynchronously -> all outputs 0 immediately; after release req_ready=1, pend_count=0.
- Single write: push (r5, 0xDEADBEEF) at edge N -> ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF in the cycle after edge N+1; low afterwards.
- Fill and stall: wb_stall=1, push r1..r4 -> pend_count=4, req_ready=0, 5th request held. Release stall -> writes r1,r2,r3,r4 on consecutive cycles; 5th accepted at the first pop.
- r0 drop: push (r0, 0x1234) -> accepted, pend_count stays 0, no ctrl_writeEnable, hazardA=0 with chk_regA=0.
- Hazard/bypass: queue (r7,0x11) then (r7,0x22), stall=1, chk_regA=7 -> hazardA=1. With WB_BYPASS_EN, byp_dataA=0x22; without it, byp_validA=0.
- Flush with push: 2 pending plus req_valid and flush in the same cycle -> next cycle pend_count=0, ctrl_writeEnable=0, new request not taken, hazards clear.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants used by the writeback initiator and its FIFO.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned WB_DEPTH   = 4;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_wb_initiator_if.sv
// Writeback request channel plus the register file write port.
import regfile_pkg::*;

interface regfile_wb_initiator_if #(
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_reg;
    logic [DATA_W-1:0] req_data;
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;

    // Initiator side: takes requests, drives the regfile write port.
    modport master (
        input  req_valid, req_reg, req_data,
        output req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );

    // Producer/regfile side.
    modport slave (
        output req_valid, req_reg, req_data,
        input  req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );
endinterface

// File: rtl/wb_fifo.sv
// Pending-write FIFO. Presents its entries oldest-first (slot 0 = head) so
// the top can run hazard/bypass compares without knowing pointer positions.
// Entry data is only exported when WB_BYPASS_EN is defined.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH  = WB_DEPTH,
    parameter  int unsigned ADDR_W = REG_ADDR_W,
    parameter  int unsigned DATA_W = REG_DATA_W,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          push,
    input  logic                          pop,
    input  logic [ADDR_W-1:0]             push_reg,
    input  logic [DATA_W-1:0]             push_data,
    output logic [CNT_W-1:0]              count,
    output logic                          full,
    output logic                          empty,
    output logic [ADDR_W-1:0]             head_reg,
    output logic [DATA_W-1:0]             head_data,
`ifdef WB_BYPASS_EN
    output logic [DEPTH-1:0][DATA_W-1:0]  ent_data,
`endif
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_reg
);

    logic [ADDR_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Pointers wrap modulo DEPTH; count alone separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_reg[wr_ptr]  <= push_reg;
            mem_data[wr_ptr] <= push_data;
        end
    end

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_reg  = mem_reg[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Age-ordered view of the queue.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ent_valid[k] = (CNT_W'(k) < count);
            ent_reg[k]   = mem_reg[rd_ptr + PTR_W'(k)];
`ifdef WB_BYPASS_EN
            ent_data[k]  = mem_data[rd_ptr + PTR_W'(k)];
`endif
        end
    end

endmodule

// File: rtl/regfile_wb_initiator.sv
// Write-side initiator for the 32x32 register file: queues writebacks,
// issues one registered write per cycle and flags read-after-write hazards.
// Define WB_BYPASS_EN to build the youngest-match bypass path for port A.
module regfile_wb_initiator
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic                          clock,
    input  logic                          ctrl_reset,
    regfile_wb_initiator_if.master        bus,
    input  logic                          flush,
    input  logic                          wb_stall,
    input  logic [ADDR_W-1:0]             chk_regA,
    input  logic [ADDR_W-1:0]             chk_regB,
    output logic                          hazardA,
    output logic                          hazardB,
    output logic                          byp_validA,
    output logic [DATA_W-1:0]             byp_dataA,
    output logic [$clog2(DEPTH+1)-1:0]    pend_count
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic                         ready_en_q;
    logic                         full;
    logic                         empty;
    logic                         accept;
    logic                         push;
    logic                         pop;
    logic [ADDR_W-1:0]            head_reg;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_reg;
`ifdef WB_BYPASS_EN
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
`endif
    logic                         we_q;
    logic [ADDR_W-1:0]            wreg_q;
    logic [DATA_W-1:0]            wdata_q;

    // Keeps req_ready low until the first edge after reset release.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) ready_en_q <= 1'b0;
        else             ready_en_q <= 1'b1;
    end

    assign bus.req_ready = ready_en_q && !full && !flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = accept && (bus.req_reg != ZERO_IDX);
    assign pop           = !empty && !wb_stall && !flush;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (ctrl_reset),
        .clr       (flush),
        .push      (push),
        .pop       (pop),
        .push_reg  (bus.req_reg),
        .push_data (bus.req_data),
        .count     (pend_count),
        .full      (full),
        .empty     (empty),
        .head_reg  (head_reg),
        .head_data (head_data),
`ifdef WB_BYPASS_EN
        .ent_data  (ent_data),
`endif
        .ent_valid (ent_valid),
        .ent_reg   (ent_reg)
    );

    // Issue register: head moves here on a pop; flush kills the next strobe.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else if (pop) begin
            we_q    <= 1'b1;
            wreg_q  <= head_reg;
            wdata_q <= head_data;
        end else begin
            we_q    <= 1'b0;
        end
    end

    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;

    // Hazard compare against queued entries and the live output strobe.
    always_comb begin
        hazardA = we_q && (wreg_q == chk_regA);
        hazardB = we_q && (wreg_q == chk_regB);
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_valid[k] && (ent_reg[k] == chk_regA)) hazardA = 1'b1;
            if (ent_valid[k] && (ent_reg[k] == chk_regB)) hazardB = 1'b1;
        end
        if (chk_regA == ZERO_IDX) hazardA = 1'b0;
        if (chk_regB == ZERO_IDX) hazardB = 1'b0;
    end

`ifdef WB_BYPASS_EN
    assign byp_validA = hazardA;

    // Youngest match wins: later (younger) slots overwrite the output stage.
    always_comb begin
        byp_dataA = '0;
        if (chk_regA != ZERO_IDX) begin
            if (we_q && (wreg_q == chk_regA)) byp_dataA = wdata_q;
            for (int k = 0; k < DEPTH; k++) begin
                if (ent_valid[k] && (ent_reg[k] == chk_regA)) byp_dataA = ent_data[k];
            end
        end
    end
`else
    assign byp_validA = 1'b0;
    assign byp_dataA  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_initiator.sv
// Directed bench for regfile_wb_initiator with hand-computed expectations.
module tb_regfile_wb_initiator;
    import regfile_pkg::*;

    logic        clock;
    logic        ctrl_reset;
    logic        flush;
    logic        wb_stall;
    logic [4:0]  chk_regA;
    logic [4:0]  chk_regB;
    logic        hazardA;
    logic        hazardB;
    logic        byp_validA;
    logic [31:0] byp_dataA;
    logic [2:0]  pend_count;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_initiator_if bus ();

    regfile_wb_initiator dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus),
        .flush      (flush),
        .wb_stall   (wb_stall),
        .chk_regA   (chk_regA),
        .chk_regB   (chk_regB),
        .hazardA    (hazardA),
        .hazardB    (hazardB),
        .byp_validA (byp_validA),
        .byp_dataA  (byp_dataA),
        .pend_count (pend_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.req_valid = v;
        bus.req_reg   = r;
        bus.req_data  = d;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        check({tag, "_we"},   32'(bus.ctrl_writeEnable), 32'(we));
        check({tag, "_reg"},  32'(bus.ctrl_writeReg),    32'(r));
        check({tag, "_data"}, bus.data_writeReg,         d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_reset = 1'b0;
        flush      = 1'b0;
        wb_stall   = 1'b0;
        chk_regA   = 5'd0;
        chk_regB   = 5'd0;
        req(1'b0, 5'd0, 32'h0);
        #3;
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_pend",  32'(pend_count),    32'h0);
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        tick();
        ctrl_reset = 1'b1;
        tick();
        check("rel_ready", 32'(bus.req_ready), 32'h1);

        // Single write: accept at edge N, strobe after edge N+1.
        req(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        req(1'b0, 5'd0, 32'h0);
        check("sw_pend", 32'(pend_count), 32'h1);
        check("sw_we0",  32'(bus.ctrl_writeEnable), 32'h0);
        tick();
        check_wr("sw", 1'b1, 5'd5, 32'hDEADBEEF);
        check("sw_pend0", 32'(pend_count), 32'h0);
        tick();
        check_wr("sw_after", 1'b0, 5'd5, 32'hDEADBEEF);

        // Fill under stall, then drain; held 5th request enters on first pop.
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            req(1'b1, 5'(i), 32'h100 + 32'(i));
            tick();
        end
        check("fill_pend", 32'(pend_count), 32'h4);
        req(1'b1, 5'd5, 32'h105);
        #1;
        check("full_ready", 32'(bus.req_ready), 32'h0);
        tick();
        check("full_hold", 32'(pend_count), 32'h4);
        check("stall_we",  32'(bus.ctrl_writeEnable), 32'h0);
        wb_stall = 1'b0;
        tick();
        check_wr("dr1", 1'b1, 5'd1, 32'h101);
        check("dr1_pend", 32'(pend_count), 32'h3);
        tick();
        req(1'b0, 5'd0, 32'h0);
        check_wr("dr2", 1'b1, 5'd2, 32'h102);
        check("dr2_pend", 32'(pend_count), 32'h3);
        tick();
        check_wr("dr3", 1'b1, 5'd3, 32'h103);
        tick();
        check_wr("dr4", 1'b1, 5'd4, 32'h104);
        tick();
        check_wr("dr5", 1'b1, 5'd5, 32'h105);
        check("dr5_pend", 32'(pend_count), 32'h0);
        tick();
        check("dr_idle_we", 32'(bus.ctrl_writeEnable), 32'h0);

        // Register 0 is handshaked but dropped.
        req(1'b1, 5'd0, 32'h1234);
        chk_regA = 5'd0;
        #1;
        check("r0_ready", 32'(bus.req_ready), 32'h1);
        tick();
        req(1'b0, 5'd0, 32'h0);
        check("r0_pend", 32'(pend_count), 32'h0);
        check("r0_haz",  32'(hazardA),    32'h0);
        tick();
        check("r0_we", 32'(bus.ctrl_writeEnable), 32'h0);

        // Hazard and bypass: two writes to r7 held by stall.
        wb_stall = 1'b1;
        req(1'b1, 5'd7, 32'h11);
        tick();
        req(1'b1, 5'd7, 32'h22);
        tick();
        req(1'b0, 5'd0, 32'h0);
        chk_regA = 5'd7;
        chk_regB = 5'd3;
        #1;
        check("hz_a", 32'(hazardA), 32'h1);
        check("hz_b", 32'(hazardB), 32'h0);
`ifdef WB_BYPASS_EN
        check("byp_v", 32'(byp_validA), 32'h1);
        check("byp_d", byp_dataA, 32'h22);
`else
        check("byp_v", 32'(byp_validA), 32'h0);
        check("byp_d", byp_dataA, 32'h0);
`endif
        wb_stall = 1'b0;
        tick();
        check_wr("hz_w1", 1'b1, 5'd7, 32'h11);
`ifdef WB_BYPASS_EN
        check("byp_young", byp_dataA, 32'h22);
`endif
        tick();
        check_wr("hz_w2", 1'b1, 5'd7, 32'h22);
        check("hz_out_stage", 32'(hazardA), 32'h1);
`ifdef WB_BYPASS_EN
        check("byp_out", byp_dataA, 32'h22);
`endif
        tick();
        check("hz_clear", 32'(hazardA), 32'h0);

        // Flush with a concurrent request.
        wb_stall = 1'b1;
        req(1'b1, 5'd9, 32'h99);
        tick();
        req(1'b1, 5'd10, 32'hAA);
        tick();
        check("fl_pend2", 32'(pend_count), 32'h2);
        req(1'b1, 5'd11, 32'hBB);
        flush    = 1'b1;
        chk_regA = 5'd9;
        chk_regB = 5'd10;
        #1;
        check("fl_ready", 32'(bus.req_ready), 32'h0);
        check("fl_hz_pre", 32'(hazardB), 32'h1);
        tick();
        flush = 1'b0;
        req(1'b0, 5'd0, 32'h0);
        check("fl_pend", 32'(pend_count), 32'h0);
        check("fl_we",   32'(bus.ctrl_writeEnable), 32'h0);
        check("fl_hza",  32'(hazardA), 32'h0);
        check("fl_hzb",  32'(hazardB), 32'h0);
        wb_stall = 1'b0;
        chk_regA = 5'd11;
        tick();
        check("fl_nowr", 32'(bus.ctrl_writeEnable), 32'h0);
        check("fl_hz11", 32'(hazardA), 32'h0);

        // Reset mid-traffic: three queued, one strobing.
        wb_stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            req(1'b1, 5'(i), 32'h200 + 32'(i));
            tick();
        end
        req(1'b0, 5'd0, 32'h0);
        wb_stall = 1'b0;
        chk_regA = 5'd2;
        tick();
        check_wr("mt_pre", 1'b1, 5'd1, 32'h201);
        check("mt_haz_pre", 32'(hazardA), 32'h1);
        #2;
        ctrl_reset = 1'b0;
        #1;
        check_wr("mt_rst", 1'b0, 5'd0, 32'h0);
        check("mt_pend",  32'(pend_count),    32'h0);
        check("mt_ready", 32'(bus.req_ready), 32'h0);
        check("mt_haz",   32'(hazardA),       32'h0);
        check("mt_bypv",  32'(byp_validA),    32'h0);
        check("mt_bypd",  byp_dataA,          32'h0);
        ctrl_reset = 1'b1;
        tick();
        check("mt_rel_ready", 32'(bus.req_ready), 32'h1);
        check("mt_rel_pend",  32'(pend_count),    32'h0);
        tick();
        check("mt_rel_we", 32'(bus.ctrl_writeEnable), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
